// File: rtl/pio_read_fifo.sv
// FPGA-to-CPU mailbox FIFO drained over Avalon-MM (DATA at 0, STATUS at 1); optional PIO_READ_FIFO_IRQ_EN adds irq + mask at 2.
// Latency: readdata registered, valid one cycle after the read strobe; no waitrequest.
// Backpressure: none; a push into a full FIFO without a same-cycle pop is dropped and latches sticky overflow.

module pio_read_fifo_buf #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   pop,
   output logic [WIDTH-1:0]       head_data,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    head;
   logic [AW-1:0]    tail;

   // Storage needs no reset: pointers and count define which entries are live.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[tail] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            tail <= tail + AW'(1);
         end
         if (pop) begin
            head <= head + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign head_data = mem[head];

endmodule

module pio_read_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [1:0]            avs_s0_address,
   input  logic                  avs_s0_chipselect,
   input  logic                  avs_s0_read_n,
`ifdef PIO_READ_FIFO_IRQ_EN
   input  logic                  avs_s0_write_n,
   input  logic [31:0]           avs_s0_writedata,
   output logic                  irq,
`endif
   output logic [31:0]           avs_s0_readdata,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  full,
   output logic                  avail
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic                  rd;
   logic                  pop;
   logic                  push;
   logic                  ovf_set;
   logic                  ovf_clr;
   logic                  overflow;
   logic [DATA_WIDTH-1:0] head_data;
   logic [CW-1:0]         count;
   logic [31:0]           data_word;
   logic [31:0]           status_word;
   logic [31:0]           rdata_nxt;

   assign rd    = avs_s0_chipselect && !avs_s0_read_n;
   assign full  = (count == FULL_CNT);
   assign avail = (count != '0);

   // A pop frees a slot on the same edge, so a push into a full FIFO is still taken when paired with a pop.
   assign pop     = rd && (avs_s0_address == 2'd0) && avail;
   assign push    = wr_en && (!full || pop);
   assign ovf_set = wr_en && full && !pop;
   assign ovf_clr = rd && (avs_s0_address == 2'd1);

   pio_read_fifo_buf #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (DEPTH)
   ) u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (wr_data),
      .pop       (pop),
      .head_data (head_data),
      .count     (count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow <= 1'b0;
      end else if (ovf_set) begin
         overflow <= 1'b1;
      end else if (ovf_clr) begin
         overflow <= 1'b0;
      end
   end

`ifdef PIO_READ_FIFO_IRQ_EN
   logic [1:0] irq_mask;
   logic       mask_wr;
   logic       unused_wdata;

   assign mask_wr      = avs_s0_chipselect && !avs_s0_write_n && (avs_s0_address == 2'd2);
   assign unused_wdata = ^avs_s0_writedata[31:2];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_mask <= 2'b00;
         irq      <= 1'b0;
      end else begin
         if (mask_wr) begin
            irq_mask <= avs_s0_writedata[1:0];
         end
         irq <= (irq_mask[0] && avail) || (irq_mask[1] && overflow);
      end
   end
`endif

   always_comb begin
      data_word                   = '0;
      data_word[DATA_WIDTH-1:0]   = head_data;
      status_word                 = '0;
      status_word[0]              = avail;
      status_word[1]              = full;
      status_word[2]              = overflow;
      status_word[8 +: CW]        = count;
   end

   always_comb begin
      rdata_nxt = '0;
      case (avs_s0_address)
         2'd0: begin
            if (pop) begin
               rdata_nxt = data_word;
            end
         end
         2'd1: rdata_nxt = status_word;
`ifdef PIO_READ_FIFO_IRQ_EN
         2'd2: rdata_nxt = {30'd0, irq_mask};
`endif
         default: rdata_nxt = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         avs_s0_readdata <= '0;
      end else if (rd) begin
         avs_s0_readdata <= rdata_nxt;
      end
   end

endmodule
